// File: rtl/key_event_decoder.sv
// Turns a debounced key level into one-cycle gesture events: short press,
// double click, long press and auto-repeat while held.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no gesture in progress
// PRESS1 | first press held, timing toward long press
// WAIT2  | released after a short first press, waiting for a second press
// PRESS2 | second press held, double click on release
// HOLD   | long press reached, repeat ticks while still held
module key_event_decoder #(
    parameter logic PRESS_LEVEL   = 1'b1,
    parameter int   LONG_CYCLES   = 50_000_000,
    parameter int   GAP_CYCLES    = 12_500_000,
    parameter int   REPEAT_CYCLES = 10_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_status,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_tick,
    output logic busy
);

    localparam int MAX_LG  = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int MAX_CYC = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // The counter is cleared on every state change, so in PRESS1/PRESS2 the
    // entry edge is already one pressed edge: the last one is at LONG-2.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 2);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             key_prev_q, key_prev_d;
    logic             pressed, press_edge;
    logic             short_d, double_d, long_d, repeat_d;

    always_comb begin
        pressed    = (key_status == PRESS_LEVEL);
        press_edge = pressed && (key_prev_q != PRESS_LEVEL);
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        state_d    = state_q;
        cnt_d      = cnt_inc;
        key_prev_d = key_status;
        short_d    = 1'b0;
        double_d   = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (press_edge) state_d = PRESS1;
            end
            PRESS1: begin
                if (!pressed) begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            WAIT2: begin
                // Expiry beats a coincident press; that press must be re-seen
                // as a fresh edge, so key_prev is forced to released.
                if (cnt_q == GAP_LAST) begin
                    short_d    = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = '0;
                    key_prev_d = ~PRESS_LEVEL;
                end else if (pressed) begin
                    state_d = PRESS2;
                    cnt_d   = '0;
                end
            end
            PRESS2: begin
                if (!pressed) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            key_prev_q   <= PRESS_LEVEL;
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            repeat_tick  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_prev_q   <= key_prev_d;
            short_press  <= short_d;
            double_click <= double_d;
            long_press   <= long_d;
            repeat_tick  <= repeat_d;
            busy         <= (state_d != IDLE);
        end
    end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Sits directly downstream of the key debounce stage and consumes its debounced key_status level.
- Classifies each gesture into one of four single-cycle event pulses: short press, double click, long press, and auto-repeat while held.
- Feeds control FSMs such as mode select and value increment.
- key_status is already synchronous to sys_clk, so the block has no input synchroniser.

Parameters:
- PRESS_LEVEL, 1, level of key_status that means "pressed".
- LONG_CYCLES, 50_000_000, hold duration for long press (1 s at 50 MHz).
- GAP_CYCLES, 12_500_000, maximum released gap between two presses that still counts as a double click (250 ms).
- REPEAT_CYCLES, 10_000_000, repeat pulse period after a long press (200 ms).

Ports:
- sys_clk, input, 1, system clock (50 MHz).
- sys_rst, input, 1, synchronous reset, active-high.
- key_status, input, 1, debounced key level from the debounce stage.
- short_press, output, 1, one-cycle pulse.
- double_click, output, 1, one-cycle pulse.
- long_press, output, 1, one-cycle pulse.
- repeat_tick, output, 1, one-cycle pulse.
- busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Single clock domain; all state and all outputs are registered.
- Reset (sys_rst=1 at a rising edge):
  - state=IDLE, counter=0.
  - All pulse outputs 0, busy=0.
  - key_prev=PRESS_LEVEL, so a key held through reset produces no event until it is released and pressed again.
  - Reset mid-gesture discards the gesture; no pulse is emitted.
- Definitions: pressed = (key_status==PRESS_LEVEL); press_edge = pressed & (key_prev!=PRESS_LEVEL).
- Counter: unsigned, width $clog2(max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)+1). Cleared on every state change; saturates and never wraps.
- Pulse timing: each pulse is high for exactly one cycle, in the cycle after the edge that decides it. At most one pulse is high per cycle.
- busy = (state!=IDLE), registered.
- FSM states and transitions:
  - IDLE:
    - press_edge -> PRESS1.
  - PRESS1: counter counts pressed cycles, including the edge that detected the press.
    - Released before the count reaches LONG_CYCLES -> WAIT2.
    - Pressed for LONG_CYCLES consecutive edges -> assert long_press, go to HOLD.
  - WAIT2: counter counts released cycles.
    - Pressed while count < GAP_CYCLES -> PRESS2.
    - GAP_CYCLES released edges elapse -> assert short_press, go to IDLE.
    - If a press coincides with the expiry edge, expiry wins: short_press fires, and that press is treated as key_prev-released. It is therefore a fresh press_edge on the next cycle only if it is still held.
  - PRESS2:
    - Released before LONG_CYCLES -> assert double_click, go to IDLE.
    - Held LONG_CYCLES -> assert long_press (no double_click), go to HOLD.
  - HOLD:
    - repeat_tick every REPEAT_CYCLES edges while pressed; the first tick comes REPEAT_CYCLES after long_press.
    - Release -> IDLE, no pulse.
- Simultaneous events: a release on the same edge as LONG_CYCLES is reached counts as release; long_press does not fire.
- Parameters must be ≥2. Behaviour for smaller values is undefined.

Test Plan:
All tests use overrides PRESS_LEVEL=1, LONG_CYCLES=100, GAP_CYCLES=30, REPEAT_CYCLES=20.
1. Assert sys_rst for 2 cycles with key_status=1, release reset, hold key 200 cycles -> no pulses, busy=0 throughout. Then release 5 cycles and press again -> busy=1 on the cycle after press.
2. Press 10 cycles, release -> short_press exactly once, 30 cycles after the release edge (+1 registered). double_click, long_press and repeat_tick stay 0. busy falls with the pulse.
3. Press 10, release 29, press 10, release -> double_click once, on the cycle after the second release. short_press never asserts. Repeat with a 30-cycle gap -> short_press at gap expiry, then the second press starts a new gesture that ends in short_press.
4. Press and hold 165 cycles -> long_press at press+100, repeat_tick at +120, +140 and +160. Release -> no further pulses, busy=0 next cycle.
5. Press exactly 99 cycles -> short path (short_press after gap). Press exactly 100 cycles -> long_press once, no short_press.
6. Assert sys_rst mid-PRESS2, then key_status=0 -> all outputs 0 the next cycle and no pulse for the aborted gesture. PRESS_LEVEL=0 variant of scenario 2 with inverted stimulus -> identical pulse timing.
